// File: rtl/lcd_ctrl_pkg.sv
// Shared encodings and constants for the parametrised HD44780-class LCD write controller.
package lcd_ctrl_pkg;

   typedef enum logic [2:0] {
      S_POWERUP,
      S_INIT,
      S_IDLE,
      S_SETUP,
      S_EN,
      S_HOLD,
      S_WAIT
   } lcd_state_e;

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   // Upper seven bits shared by home (0x02) and its don't-care variant (0x03).
   localparam logic [6:0] CMD_HOME      = 7'b0000001;
   localparam logic [7:0] INIT_BYTE     = 8'h30;
   localparam logic [3:0] INIT_NIB      = 4'h3;
   localparam logic [3:0] INIT_NIB_LAST = 4'h2;
   localparam int         INIT_STEPS_8  = 3;
   localparam int         INIT_STEPS_4  = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_ctrl_param_if.sv
// Word handshake between the text sequencer and the LCD controller: {rs, byte} with valid/ready.
interface lcd_ctrl_param_if;
   logic [8:0] data;
   logic       data_valid;
   logic       ready;

   modport master (output data, output data_valid, input ready);
   modport slave  (input data, input data_valid, output ready);
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter; done while the count sits at zero.
module lcd_timer #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)              cnt <= RST_VAL;
      else if (load)        cnt <= load_val;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl_param.sv
// HD44780-class write controller: timed E pulses for 8- or 4-bit bus, long waits for clear/home,
// optional power-on init sequence.
module lcd_ctrl_param
   import lcd_ctrl_pkg::*;
#(
   parameter bit BUS_4BIT    = 1'b0,
   parameter int T_SETUP     = 2,
   parameter int T_EN        = 12,
   parameter int T_HOLD      = 2,
   parameter int T_EXEC      = 2000,
   parameter int T_EXEC_LONG = 80000,
   parameter bit INIT_EN     = 1'b1,
   parameter int T_POWERUP   = 1500000
) (
   input  logic                clk,
   input  logic                rst,
   lcd_ctrl_param_if.slave     bus,
   output logic                lcd_rs,
   output logic                lcd_rw,
   output logic [7:0]          lcd_data,
   output logic                lcd_enable
);

   localparam int T_MAX = max_int(max_int(max_int(T_SETUP, T_EN), max_int(T_HOLD, T_EXEC)),
                                  max_int(T_EXEC_LONG, T_POWERUP));
   localparam int TW = $clog2(T_MAX) + 1;

   localparam logic [TW-1:0] LD_SETUP   = TW'(T_SETUP - 1);
   localparam logic [TW-1:0] LD_EN      = TW'(T_EN - 1);
   localparam logic [TW-1:0] LD_HOLD    = TW'(T_HOLD - 1);
   localparam logic [TW-1:0] LD_EXEC    = TW'(T_EXEC - 1);
   localparam logic [TW-1:0] LD_LONG    = TW'(T_EXEC_LONG - 1);
   localparam logic [TW-1:0] LD_RST     = INIT_EN ? TW'(T_POWERUP - 1) : '0;
   localparam logic [2:0]    N_INIT     = BUS_4BIT ? 3'(INIT_STEPS_4) : 3'(INIT_STEPS_8);

   lcd_state_e    state, state_n;
   logic          ready_q;
   logic [8:0]    word_q;
   logic          second;
   logic          init_run;
   logic [2:0]    init_cnt;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_done;
   logic          accept;
   logic          nib_next;
   logic          long_wait;
   logic [7:0]    init_word;

   lcd_timer #(.W(TW), .RST_VAL(LD_RST)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign bus.ready = ready_q;
   assign lcd_rw    = 1'b0;
   assign accept    = ready_q && bus.data_valid;
   assign nib_next  = BUS_4BIT && !second && !init_run;
   // Init steps always take the long wait; user words only for clear/home with rs=0.
   assign long_wait = init_run ||
                      (!word_q[8] && (word_q[7:0] == CMD_CLEAR || word_q[7:1] == CMD_HOME));
   assign init_word = !BUS_4BIT ? INIT_BYTE :
                      {(init_cnt == N_INIT - 3'd1) ? INIT_NIB_LAST : INIT_NIB, 4'h0};

   always_ff @(posedge clk) begin
      if (rst) state <= INIT_EN ? S_POWERUP : S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         S_POWERUP: if (tmr_done) state_n = S_INIT;
         S_INIT: begin
            state_n  = S_SETUP;
            tmr_load = 1'b1;
            tmr_val  = LD_SETUP;
         end
         S_IDLE: if (accept) begin
            state_n  = S_SETUP;
            tmr_load = 1'b1;
            tmr_val  = LD_SETUP;
         end
         S_SETUP: if (tmr_done) begin
            state_n  = S_EN;
            tmr_load = 1'b1;
            tmr_val  = LD_EN;
         end
         S_EN: if (tmr_done) begin
            state_n  = S_HOLD;
            tmr_load = 1'b1;
            tmr_val  = LD_HOLD;
         end
         S_HOLD: if (tmr_done) begin
            tmr_load = 1'b1;
            if (nib_next) begin
               state_n = S_SETUP;
               tmr_val = LD_SETUP;
            end else begin
               state_n = S_WAIT;
               tmr_val = long_wait ? LD_LONG : LD_EXEC;
            end
         end
         S_WAIT: if (tmr_done) begin
            state_n = (init_run && init_cnt != N_INIT) ? S_INIT : S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q    <= 1'b0;
         lcd_enable <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_data   <= 8'h00;
         word_q     <= 9'h000;
         second     <= 1'b0;
         init_run   <= 1'b0;
         init_cnt   <= 3'd0;
      end else begin
         ready_q    <= (state_n == S_IDLE);
         lcd_enable <= (state_n == S_EN);
         if (accept) begin
            word_q   <= bus.data;
            lcd_rs   <= bus.data[8];
            lcd_data <= BUS_4BIT ? {bus.data[7:4], 4'h0} : bus.data[7:0];
            second   <= 1'b0;
         end
         if (state == S_HOLD && tmr_done && nib_next) begin
            lcd_data <= {word_q[3:0], 4'h0};
            second   <= 1'b1;
         end
         if (state == S_POWERUP && tmr_done) init_run <= 1'b1;
         if (state == S_INIT) begin
            lcd_rs   <= 1'b0;
            lcd_data <= init_word;
            init_cnt <= init_cnt + 3'd1;
         end
         if (state == S_WAIT && state_n == S_IDLE) init_run <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: 8-bit, 4-bit and 4-bit-with-init instances, E pulses scored against a queue.
module tb_lcd_ctrl_param;

   localparam int T_SETUP = 2, T_EN = 4, T_HOLD = 2, T_EXEC = 10, T_EXEC_LONG = 40, T_POWERUP = 20;

   typedef struct {
      int         dut;
      logic       rs;
      logic [7:0] data;
   } pulse_t;

   logic       clk = 1'b0;
   logic [2:0] rst = 3'b111;
   logic [2:0] dv  = 3'b000;
   logic [8:0] dat [3];
   logic [2:0] rdy, e, rs_o, rw_o;
   logic [7:0] d_o [3];

   pulse_t     exp_q[$];
   pulse_t     mon_p;
   int         n_chk = 0, n_pass = 0;
   logic [2:0] e_q = 3'b000, abort = 3'b000;
   int         e_len [3];
   int         n_rise [3];
   logic [7:0] cap_d [3];

   always #5 clk = ~clk;

   lcd_ctrl_param_if if0 ();
   lcd_ctrl_param_if if1 ();
   lcd_ctrl_param_if if2 ();

   assign if0.data = dat[0]; assign if0.data_valid = dv[0]; assign rdy[0] = if0.ready;
   assign if1.data = dat[1]; assign if1.data_valid = dv[1]; assign rdy[1] = if1.ready;
   assign if2.data = dat[2]; assign if2.data_valid = dv[2]; assign rdy[2] = if2.ready;

   lcd_ctrl_param #(.BUS_4BIT(0), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD), .T_EXEC(T_EXEC),
      .T_EXEC_LONG(T_EXEC_LONG), .INIT_EN(0), .T_POWERUP(T_POWERUP)) u_dut8 (
      .clk(clk), .rst(rst[0]), .bus(if0), .lcd_rs(rs_o[0]), .lcd_rw(rw_o[0]),
      .lcd_data(d_o[0]), .lcd_enable(e[0]));

   lcd_ctrl_param #(.BUS_4BIT(1), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD), .T_EXEC(T_EXEC),
      .T_EXEC_LONG(T_EXEC_LONG), .INIT_EN(0), .T_POWERUP(T_POWERUP)) u_dut4 (
      .clk(clk), .rst(rst[1]), .bus(if1), .lcd_rs(rs_o[1]), .lcd_rw(rw_o[1]),
      .lcd_data(d_o[1]), .lcd_enable(e[1]));

   lcd_ctrl_param #(.BUS_4BIT(1), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD), .T_EXEC(T_EXEC),
      .T_EXEC_LONG(T_EXEC_LONG), .INIT_EN(1), .T_POWERUP(T_POWERUP)) u_duti (
      .clk(clk), .rst(rst[2]), .bus(if2), .lcd_rs(rs_o[2]), .lcd_rw(rw_o[2]),
      .lcd_data(d_o[2]), .lcd_enable(e[2]));

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
   endtask

   function automatic bit is4(input int i);
      return i != 0;
   endfunction

   task automatic push(input int i, input logic rs, input logic [7:0] d);
      pulse_t p;
      p.dut = i; p.rs = rs; p.data = d;
      exp_q.push_back(p);
   endtask

   // Model: expected pulses and busy length derived from the word alone.
   task automatic send(input int i, input logic [8:0] w);
      int n, e_at, busy;
      bit lng;
      lng  = (w[8] == 1'b0) && (w[7:0] == 8'h01 || w[7:0] == 8'h02 || w[7:0] == 8'h03);
      busy = (is4(i) ? 2 : 1) * (T_SETUP + T_EN + T_HOLD) + (lng ? T_EXEC_LONG : T_EXEC);
      n = 0;
      while (!rdy[i] && n < 500) begin @(posedge clk); #1; n++; end
      chk("ready_before_send", int'(rdy[i]), 1);
      if (is4(i)) begin
         push(i, w[8], {w[7:4], 4'h0});
         push(i, w[8], {w[3:0], 4'h0});
      end else push(i, w[8], w[7:0]);
      dat[i] = w; dv[i] = 1'b1;
      @(posedge clk); #1;
      dv[i] = 1'b0; dat[i] = 9'($urandom);
      n = 0; e_at = -1;
      while (!rdy[i] && n < busy + 100) begin
         @(posedge clk); #1; n++;
         if (e[i] && e_at < 0) e_at = n;
      end
      chk("e_start", e_at, T_SETUP);
      chk("busy_len", n, busy);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (e[i] && !e_q[i]) begin
            n_rise[i]++;
            chk("rw_low", int'(rw_o[i]), 0);
            if (exp_q.size() == 0) chk("pulse_expected", 0, 1);
            else begin
               mon_p = exp_q.pop_front();
               chk("pulse_dut", i, mon_p.dut);
               chk("pulse_rs", int'(rs_o[i]), int'(mon_p.rs));
               chk("pulse_data", int'(d_o[i]), int'(mon_p.data));
            end
            cap_d[i] = d_o[i];
            e_len[i] = 1;
         end else if (e[i]) e_len[i]++;
         else if (e_q[i]) begin
            if (abort[i]) abort[i] = 1'b0;
            else begin
               chk("e_width", e_len[i], T_EN);
               chk("data_hold", int'(d_o[i]), int'(cap_d[i]));
            end
         end
         e_q[i] = e[i];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, bad, rises;
      for (int i = 0; i < 3; i++) begin dat[i] = '0; e_len[i] = 0; n_rise[i] = 0; cap_d[i] = '0; end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_ready", int'(rdy[i]), 0);
         chk("rst_out", int'({rs_o[i], rw_o[i], e[i], d_o[i]}), 0);
      end

      rst[1:0] = 2'b00;
      @(posedge clk); #1;
      chk("ready_after_rst8", int'(rdy[0]), 1);
      chk("ready_after_rst4", int'(rdy[1]), 1);

      // 8-bit: data, clear/home long waits and their neighbours.
      send(0, 9'h141);
      send(0, 9'h001);
      send(0, 9'h101);
      send(0, 9'h000);
      send(0, 9'h003);
      send(0, 9'h004);
      // 4-bit: two nibble pulses per word.
      send(1, 9'h128);
      send(1, 9'h002);
      send(1, 9'h1A5);

      // Power-on init on the 4-bit instance.
      push(2, 1'b0, 8'h30); push(2, 1'b0, 8'h30); push(2, 1'b0, 8'h30); push(2, 1'b0, 8'h20);
      rst[2] = 1'b0;
      bad = 0;
      for (int k = 0; k < T_POWERUP; k++) begin
         @(posedge clk); #1;
         if (rdy[2] || e[2]) bad++;
      end
      chk("powerup_quiet", bad, 0);
      n = 0; bad = 0;
      while (!rdy[2] && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      chk("init_ready", int'(rdy[2]), 1);
      chk("init_pulses_left", exp_q.size(), 0);
      chk("init_pulse_count", n_rise[2], 4);
      send(2, 9'h141);

      // Reset in the middle of the E pulse.
      push(0, 1'b1, 8'h41);
      rises = n_rise[0];
      dat[0] = 9'h141; dv[0] = 1'b1;
      @(posedge clk); #1;
      dv[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("e_before_rst", int'(e[0]), 1);
      abort[0] = 1'b1; rst[0] = 1'b1;
      @(posedge clk); #1;
      chk("rst_cut_e", int'(e[0]), 0);
      chk("rst_cut_ready", int'(rdy[0]), 0);
      chk("rst_cut_out", int'({rs_o[0], d_o[0]}), 0);
      rst[0] = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_midrst", int'(rdy[0]), 1);
      repeat (60) @(posedge clk);
      #1;
      chk("no_pulse_after_rst", n_rise[0] - rises, 1);
      chk("queue_empty_end", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
